// File: rtl/operand_entry.sv
// Operand entry: captures switch values into NUM_OPS packed slots with undo/clear/ack.
// Define OPERAND_CONFIRM_EDGE_EN to act on confirm/undo rising edges instead of levels.
module operand_entry #(
  parameter int WIDTH   = 4,
  parameter int NUM_OPS = 2,
  localparam int IDX_W  = (NUM_OPS > 2) ? $clog2(NUM_OPS) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [WIDTH-1:0]         sw,
  input  logic                     confirm,
  input  logic                     undo,
  input  logic                     clear,
  input  logic                     ack,
  output logic [WIDTH*NUM_OPS-1:0] operands,
  output logic [IDX_W-1:0]         slot_idx,
  output logic                     ops_valid
);

  typedef enum logic {COLLECT, FULL} state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_OPS - 1);

  state_t                   state;
  state_t                   state_next;
  logic [WIDTH*NUM_OPS-1:0] operands_next;
  logic [IDX_W-1:0]         idx_next;
  logic                     confirm_q;
  logic                     undo_q;

`ifdef OPERAND_CONFIRM_EDGE_EN
  logic confirm_prev;
  logic undo_prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      confirm_prev <= 1'b0;
      undo_prev    <= 1'b0;
    end else begin
      confirm_prev <= confirm;
      undo_prev    <= undo;
    end
  end

  assign confirm_q = confirm & ~confirm_prev;
  assign undo_q    = undo & ~undo_prev;
`else
  assign confirm_q = confirm;
  assign undo_q    = undo;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= COLLECT;
      operands <= '0;
      slot_idx <= '0;
    end else begin
      state    <= state_next;
      operands <= operands_next;
      slot_idx <= idx_next;
    end
  end

  // Priority: clear > ack (FULL only) > undo > confirm (COLLECT only).
  always_comb begin
    state_next    = state;
    operands_next = operands;
    idx_next      = slot_idx;
    if (clear) begin
      state_next    = COLLECT;
      operands_next = '0;
      idx_next      = '0;
    end else if (ack && state == FULL) begin
      state_next = COLLECT;
      idx_next   = '0;
    end else if (undo_q) begin
      if (state == FULL) begin
        operands_next[(NUM_OPS-1)*WIDTH +: WIDTH] = '0;
        state_next = COLLECT;
        idx_next   = LAST_IDX;
      end else if (slot_idx != '0) begin
        idx_next = slot_idx - 1'b1;
        for (int k = 0; k < NUM_OPS; k++) begin
          if (IDX_W'(k) == idx_next) operands_next[k*WIDTH +: WIDTH] = '0;
        end
      end
    end else if (confirm_q && state == COLLECT) begin
      for (int k = 0; k < NUM_OPS; k++) begin
        if (IDX_W'(k) == slot_idx) operands_next[k*WIDTH +: WIDTH] = sw;
      end
      if (slot_idx == LAST_IDX) state_next = FULL;
      else idx_next = slot_idx + 1'b1;
    end
  end

  always_comb begin
    ops_valid = (state == FULL);
  end

endmodule

// File: tb/tb_operand_entry.sv
// Scoreboard bench for operand_entry: a default instance and a NUM_OPS=3 instance share stimulus.
module tb_operand_entry;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  sw;
  logic        confirm, undo, clear, ack;
  logic [7:0]  operands0;
  logic [0:0]  slot_idx0;
  logic        ops_valid0;
  logic [11:0] operands1;
  logic [1:0]  slot_idx1;
  logic        ops_valid1;

  always #5 clk = ~clk;

  operand_entry dut0 (
    .clk(clk), .reset(reset), .sw(sw), .confirm(confirm), .undo(undo),
    .clear(clear), .ack(ack), .operands(operands0), .slot_idx(slot_idx0),
    .ops_valid(ops_valid0)
  );

  operand_entry #(.WIDTH(4), .NUM_OPS(3)) dut1 (
    .clk(clk), .reset(reset), .sw(sw), .confirm(confirm), .undo(undo),
    .clear(clear), .ack(ack), .operands(operands1), .slot_idx(slot_idx1),
    .ops_valid(ops_valid1)
  );

  typedef struct packed {
    logic [7:0]  op0;
    logic [0:0]  idx0;
    logic        v0;
    logic [11:0] op1;
    logic [1:0]  idx1;
    logic        v1;
  } exp_t;

  exp_t sbq[$];
  int   tests = 0;
  int   fails = 0;

  // Reference model: slot contents per instance, next index, full flag, press history.
  int m_slot[2][3];
  int m_idx[2];
  bit m_full[2];
  bit m_pc, m_pu;

  function automatic void modelReset();
    for (int d = 0; d < 2; d++) begin
      for (int j = 0; j < 3; j++) m_slot[d][j] = 0;
      m_idx[d]  = 0;
      m_full[d] = 1'b0;
    end
    m_pc = 1'b0;
    m_pu = 1'b0;
  endfunction

  function automatic void modelStep(bit clr, bit ak, bit un, bit cf, logic [3:0] s);
    bit cq, uq;
    int n;
`ifdef OPERAND_CONFIRM_EDGE_EN
    cq = cf && !m_pc;
    uq = un && !m_pu;
`else
    cq = cf;
    uq = un;
`endif
    for (int d = 0; d < 2; d++) begin
      n = (d == 0) ? 2 : 3;
      if (clr) begin
        for (int j = 0; j < 3; j++) m_slot[d][j] = 0;
        m_idx[d]  = 0;
        m_full[d] = 1'b0;
      end else if (ak && m_full[d]) begin
        m_idx[d]  = 0;
        m_full[d] = 1'b0;
      end else if (uq) begin
        if (m_full[d]) begin
          m_slot[d][n-1] = 0;
          m_idx[d]       = n - 1;
          m_full[d]      = 1'b0;
        end else if (m_idx[d] > 0) begin
          m_idx[d] = m_idx[d] - 1;
          m_slot[d][m_idx[d]] = 0;
        end
      end else if (cq && !m_full[d]) begin
        m_slot[d][m_idx[d]] = int'(s);
        if (m_idx[d] == n - 1) m_full[d] = 1'b1;
        else m_idx[d] = m_idx[d] + 1;
      end
    end
    m_pc = cf;
    m_pu = un;
  endfunction

  function automatic exp_t modelSnapshot();
    exp_t e;
    e.op0  = {4'(m_slot[0][1]), 4'(m_slot[0][0])};
    e.idx0 = 1'(m_idx[0]);
    e.v0   = m_full[0];
    e.op1  = {4'(m_slot[1][2]), 4'(m_slot[1][1]), 4'(m_slot[1][0])};
    e.idx1 = 2'(m_idx[1]);
    e.v1   = m_full[1];
    return e;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic checkScoreboard();
    exp_t e;
    checkOutput("sb_depth", sbq.size(), 1);
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      checkOutput("operands0", operands0, e.op0);
      checkOutput("slot_idx0", slot_idx0, e.idx0);
      checkOutput("ops_valid0", ops_valid0, e.v0);
      checkOutput("operands1", operands1, e.op1);
      checkOutput("slot_idx1", slot_idx1, e.idx1);
      checkOutput("ops_valid1", ops_valid1, e.v1);
    end
  endtask

  // Drives one cycle from a falling edge, predicts it, checks just after the rising edge.
  task automatic applyStimulus(input bit clr, input bit ak, input bit un, input bit cf,
                               input logic [3:0] s);
    clear   = clr;
    ack     = ak;
    undo    = un;
    confirm = cf;
    sw      = s;
    modelStep(clr, ak, un, cf, s);
    sbq.push_back(modelSnapshot());
    @(posedge clk);
    #1;
    checkScoreboard();
    @(negedge clk);
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
  endtask

  task automatic capture(input logic [3:0] s);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, s);
    idle();
  endtask

  initial begin
    reset = 1'b1; sw = '0; confirm = 0; undo = 0; clear = 0; ack = 0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_ops0", operands0, 8'h00);
    checkOutput("rst_idx0", slot_idx0, 1'b0);
    checkOutput("rst_v0", ops_valid0, 1'b0);
    checkOutput("rst_ops1", operands1, 12'h000);
    checkOutput("rst_idx1", slot_idx1, 2'd0);
    checkOutput("rst_v1", ops_valid1, 1'b0);
    @(negedge clk);
    reset = 1'b0;

    // Boundaries in COLLECT: undo at slot 0 and ack are both no-ops.
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 4'h0);
    checkOutput("undo_at0_idx", slot_idx0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
    checkOutput("ack_collect_v", ops_valid0, 1'b0);

    // Basic fill on the default instance.
    capture(4'h3);
    capture(4'h9);
    checkOutput("fill_ops0", operands0, 8'h93);
    checkOutput("fill_v0", ops_valid0, 1'b1);
    checkOutput("fill_idx0", slot_idx0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 4'hF);
    checkOutput("full_confirm_ops0", operands0, 8'h93);
    checkOutput("full_confirm_ops1", operands1, 12'hF93);
    idle();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
    checkOutput("ack_v0", ops_valid0, 1'b0);
    checkOutput("ack_idx0", slot_idx0, 1'b0);
    checkOutput("ack_ops0", operands0, 8'h93);

    // Undo from FULL on the three-slot instance.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
    capture(4'h5);
    capture(4'h6);
    capture(4'h7);
    checkOutput("undo_pre_v1", ops_valid1, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 4'h0);
    checkOutput("undo_ops1", operands1, 12'h065);
    checkOutput("undo_idx1", slot_idx1, 2'd2);
    checkOutput("undo_v1", ops_valid1, 1'b0);
    checkOutput("undo_ops0", operands0, 8'h05);
    idle();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 4'hA);
    checkOutput("refill_ops1", operands1, 12'hA65);
    checkOutput("refill_v1", ops_valid1, 1'b1);

    // Priority: ack beats undo, clear beats everything.
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 4'h0);
    checkOutput("ackundo_ops1", operands1, 12'hA65);
    checkOutput("ackundo_idx1", slot_idx1, 2'd0);
    checkOutput("ackundo_v1", ops_valid1, 1'b0);
    capture(4'h1);
    capture(4'h2);
    capture(4'h3);
    checkOutput("prio_pre_v0", ops_valid0, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 4'h7);
    checkOutput("clear_ops0", operands0, 8'h00);
    checkOutput("clear_ops1", operands1, 12'h000);
    checkOutput("clear_v1", ops_valid1, 1'b0);
    checkOutput("clear_idx1", slot_idx1, 2'd0);

    // Held confirm for four cycles.
    idle();
    repeat (4) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 4'h2);
    idle();
`ifdef OPERAND_CONFIRM_EDGE_EN
    checkOutput("held_ops0", operands0, 8'h02);
    checkOutput("held_idx0", slot_idx0, 1'b1);
    checkOutput("held_ops1", operands1, 12'h002);
    checkOutput("held_idx1", slot_idx1, 2'd1);
`else
    checkOutput("held_ops0", operands0, 8'h22);
    checkOutput("held_v0", ops_valid0, 1'b1);
    checkOutput("held_ops1", operands1, 12'h222);
    checkOutput("held_idx1", slot_idx1, 2'd2);
`endif

    // Asynchronous reset between edges after one capture.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
    capture(4'h8);
    #2;
    reset = 1'b1;
    modelReset();
    #1;
    checkOutput("arst_ops0", operands0, 8'h00);
    checkOutput("arst_idx0", slot_idx0, 1'b0);
    checkOutput("arst_ops1", operands1, 12'h000);
    checkOutput("arst_v1", ops_valid1, 1'b0);
    confirm = 1'b1;
    sw      = 4'hF;
    @(posedge clk);
    #1;
    checkOutput("arst_hold_ops1", operands1, 12'h000);
    @(negedge clk);
    reset   = 1'b0;
    confirm = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 4'h4);
    checkOutput("post_rst_ops0", operands0, 8'h04);
    checkOutput("post_rst_ops1", operands1, 12'h004);

    // Random mixed traffic against the model.
    for (int i = 0; i < 80; i++) begin
      applyStimulus($urandom_range(0, 19) == 0, $urandom_range(0, 5) == 0,
                    $urandom_range(0, 4) == 0, $urandom_range(0, 1) == 1,
                    4'($urandom_range(0, 15)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
